game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl_if.sv | 31 +++
 rtl/game_ctrl.sv | 127 ++++++++++++
 tb/tb_game_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/game_ctrl_if.sv
// Bus between the game controller and the rest of the game: frame timing,
// player/ball events in, and state, ball control and scores out.
interface game_ctrl_if #(
    parameter int SCORE_W = 3
);
    logic               frame_tick_i;
    logic               start_i;
    logic               miss_player_i;
    logic               miss_pc_i;
    logic [2:0]         state_o;
    logic               ball_run_o;
    logic               ball_center_o;
    logic               serve_dir_o;
    logic [SCORE_W-1:0] score_player_o;
    logic [SCORE_W-1:0] score_pc_o;
    logic               winner_o;

    // Game-side logic that drives events and consumes the controller outputs
    modport master (
        output frame_tick_i, start_i, miss_player_i, miss_pc_i,
        input  state_o, ball_run_o, ball_center_o, serve_dir_o,
               score_player_o, score_pc_o, winner_o
    );

    // The controller itself
    modport slave (
        input  frame_tick_i, start_i, miss_player_i, miss_pc_i,
        output state_o, ball_run_o, ball_center_o, serve_dir_o,
               score_player_o, score_pc_o, winner_o
    );
endinterface

// File: rtl/game_ctrl.sv
// Pong match controller: sequences serve, rally, point freeze and game over,
// keeps both scores and tells the ball datapath whether to run or centre.
module game_ctrl #(
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input logic        clk_i,
    input logic        rst_i,
    game_ctrl_if.slave bus
);
    localparam int SCORE_W = $clog2(WIN_SCORE + 1);
    localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_FRAMES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_player_q, score_player_d;
    logic [SCORE_W-1:0] score_pc_q, score_pc_d;
    logic               serve_dir_q, serve_dir_d;

    // Register all controller state; reset returns to an idle, centred ball
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            score_player_q <= '0;
            score_pc_q     <= '0;
            serve_dir_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            score_player_q <= score_player_d;
            score_pc_q     <= score_pc_d;
            serve_dir_q    <= serve_dir_d;
        end
    end

    // Next-state rules: the shared frame counter times both serve and point phases
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        score_player_d = score_player_q;
        score_pc_d     = score_pc_q;
        serve_dir_d    = serve_dir_q;
        case (state_q)
            IDLE, OVER: begin
                if (bus.start_i) begin
                    state_d        = SERVE;
                    cnt_d          = SERVE_LOAD;
                    score_player_d = '0;
                    score_pc_d     = '0;
                    serve_dir_d    = 1'b1;
                end
            end
            SERVE: begin
                if (bus.frame_tick_i) begin
                    if (cnt_q == '0) state_d = PLAY;
                    else             cnt_d   = cnt_q - CNT_ONE;
                end
            end
            PLAY: begin
                if (bus.miss_player_i && bus.miss_pc_i) begin
                    state_d = SERVE;
                    cnt_d   = SERVE_LOAD;
                end else if (bus.miss_pc_i) begin
                    if (score_player_q != WIN_VAL) score_player_d = score_player_q + SCORE_ONE;
                    serve_dir_d = 1'b0;
                    state_d     = POINT;
                    cnt_d       = POINT_LOAD;
                end else if (bus.miss_player_i) begin
                    if (score_pc_q != WIN_VAL) score_pc_d = score_pc_q + SCORE_ONE;
                    serve_dir_d = 1'b1;
                    state_d     = POINT;
                    cnt_d       = POINT_LOAD;
                end
            end
            POINT: begin
                if (bus.frame_tick_i) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (score_player_q == WIN_VAL || score_pc_q == WIN_VAL) begin
                        state_d = OVER;
                    end else begin
                        state_d = SERVE;
                        cnt_d   = SERVE_LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore output decode of the registered state
    always_comb begin
        bus.state_o        = state_q;
        bus.ball_run_o     = 1'b0;
        bus.ball_center_o  = 1'b0;
        bus.winner_o       = 1'b0;
        bus.serve_dir_o    = serve_dir_q;
        bus.score_player_o = score_player_q;
        bus.score_pc_o     = score_pc_q;
        case (state_q)
            IDLE, SERVE: bus.ball_center_o = 1'b1;
            PLAY:        bus.ball_run_o    = 1'b1;
            OVER: begin
                bus.ball_center_o = 1'b1;
                bus.winner_o      = (score_player_q == WIN_VAL);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed match walkthrough followed by
// random play, every cycle compared against a rule-level match model.
module tb_game_ctrl;
    localparam int WIN_SCORE    = 2;
    localparam int SERVE_FRAMES = 2;
    localparam int POINT_FRAMES = 1;
    localparam int SCORE_W      = $clog2(WIN_SCORE + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model: match phase number, ticks still to wait, scores, serve side
    int mPhase     = 0;
    int mTicksLeft = 0;
    int mPlayer    = 0;
    int mPc        = 0;
    int mDir       = 1;

    game_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

    game_ctrl #(
        .WIN_SCORE(WIN_SCORE),
        .SERVE_FRAMES(SERVE_FRAMES),
        .POINT_FRAMES(POINT_FRAMES)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic newMatch();
        mPhase     = 1;
        mTicksLeft = SERVE_FRAMES;
        mPlayer    = 0;
        mPc        = 0;
        mDir       = 1;
    endtask

    // Advance the model by one clock using the match rules
    task automatic modelStep(input bit r, input bit tick, input bit start,
                             input bit missPlayer, input bit missPc);
        if (r) begin
            mPhase = 0; mTicksLeft = 0; mPlayer = 0; mPc = 0; mDir = 1;
        end else begin
            case (mPhase)
                0, 4: if (start) newMatch();
                1: if (tick) begin
                    mTicksLeft--;
                    if (mTicksLeft == 0) mPhase = 2;
                end
                2: if (missPlayer && missPc) begin
                    mPhase = 1; mTicksLeft = SERVE_FRAMES;
                end else if (missPc) begin
                    mPlayer++; mDir = 0; mPhase = 3; mTicksLeft = POINT_FRAMES;
                end else if (missPlayer) begin
                    mPc++; mDir = 1; mPhase = 3; mTicksLeft = POINT_FRAMES;
                end
                3: if (tick) begin
                    mTicksLeft--;
                    if (mTicksLeft == 0) begin
                        if (mPlayer == WIN_SCORE || mPc == WIN_SCORE) mPhase = 4;
                        else begin mPhase = 1; mTicksLeft = SERVE_FRAMES; end
                    end
                end
                default: mPhase = 0;
            endcase
        end
    endtask

    // Drive one cycle of inputs, clock it, then update the model
    task automatic applyStimulus(input bit r, input bit tick, input bit start,
                                 input bit missPlayer, input bit missPc);
        rst               = r;
        bus.frame_tick_i  = tick;
        bus.start_i       = start;
        bus.miss_player_i = missPlayer;
        bus.miss_pc_i     = missPc;
        @(posedge clk);
        #1;
        modelStep(r, tick, start, missPlayer, missPc);
    endtask

    // Compare every DUT output with the model
    task automatic checkOutput(input string tag);
        checkValue({tag, ".state"},  32'(bus.state_o),        32'(mPhase));
        checkValue({tag, ".run"},    32'(bus.ball_run_o),     32'(mPhase == 2));
        checkValue({tag, ".center"}, 32'(bus.ball_center_o),
                   32'(mPhase == 0 || mPhase == 1 || mPhase == 4));
        checkValue({tag, ".dir"},    32'(bus.serve_dir_o),    32'(mDir));
        checkValue({tag, ".sPlayer"},32'(bus.score_player_o), 32'(mPlayer));
        checkValue({tag, ".sPc"},    32'(bus.score_pc_o),     32'(mPc));
        checkValue({tag, ".winner"}, 32'(bus.winner_o),       32'(mPhase == 4 && mPlayer == WIN_SCORE));
    endtask

    task automatic step(input string tag, input bit r, input bit tick, input bit start,
                        input bit missPlayer, input bit missPc);
        applyStimulus(r, tick, start, missPlayer, missPc);
        checkOutput(tag);
    endtask

    initial begin
        bus.frame_tick_i  = 1'b0;
        bus.start_i       = 1'b0;
        bus.miss_player_i = 1'b0;
        bus.miss_pc_i     = 1'b0;

        // Reset and first serve
        step("rst0", 1, 0, 0, 0, 0);
        step("rst1", 1, 0, 0, 0, 0);
        checkValue("resetState", 32'(bus.state_o), 32'd0);
        step("start", 0, 0, 1, 0, 0);
        checkValue("serveState", 32'(bus.state_o), 32'd1);
        step("serveTick1", 0, 1, 0, 0, 0);
        checkValue("serveHold", 32'(bus.state_o), 32'd1);
        step("serveTick2", 0, 1, 0, 0, 0);
        checkValue("playState", 32'(bus.state_o), 32'd2);
        checkValue("playRun", 32'(bus.ball_run_o), 32'd1);
        step("playIdle", 0, 1, 1, 0, 0);

        // Player scores once, then a double miss replays the serve
        step("missPc1", 0, 0, 0, 0, 1);
        checkValue("point1Score", 32'(bus.score_player_o), 32'd1);
        checkValue("point1Dir", 32'(bus.serve_dir_o), 32'd0);
        step("pointTick", 0, 1, 0, 0, 0);
        checkValue("point1Serve", 32'(bus.state_o), 32'd1);
        step("serveT1", 0, 1, 0, 1, 1);
        step("serveT2", 0, 1, 0, 0, 0);
        step("doubleMiss", 0, 0, 0, 1, 1);
        checkValue("doubleState", 32'(bus.state_o), 32'd1);
        checkValue("doubleScore", 32'(bus.score_player_o), 32'd1);

        // Player reaches the winning score
        step("serveT3", 0, 1, 0, 0, 0);
        step("serveT4", 0, 1, 0, 0, 0);
        step("missPc2", 0, 0, 0, 0, 1);
        step("winTick", 0, 1, 0, 0, 0);
        checkValue("overState", 32'(bus.state_o), 32'd4);
        checkValue("overWinner", 32'(bus.winner_o), 32'd1);
        step("overMiss", 0, 1, 0, 1, 1);
        checkValue("overScore", 32'(bus.score_player_o), 32'd2);
        step("restart", 0, 0, 1, 0, 0);
        checkValue("restartScore", 32'(bus.score_player_o), 32'd0);

        // Reset in the middle of a 1/1 point
        step("s5", 0, 1, 0, 0, 0);
        step("s6", 0, 1, 0, 0, 0);
        step("missPc3", 0, 0, 0, 0, 1);
        step("s7", 0, 1, 0, 0, 0);
        step("s8", 0, 1, 0, 0, 0);
        step("s9", 0, 1, 0, 0, 0);
        step("missPl1", 0, 0, 0, 1, 0);
        checkValue("tiedPc", 32'(bus.score_pc_o), 32'd1);
        step("midRst", 1, 1, 1, 1, 1);
        checkValue("midRstState", 32'(bus.state_o), 32'd0);
        checkValue("midRstScore", 32'(bus.score_pc_o), 32'd0);
        step("idleTick", 0, 1, 0, 0, 0);
        step("idleMiss", 0, 0, 0, 1, 1);

        // Random play against the model
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
